alu_issue_ctrl: RTL and testbench

- Multi-cycle sequencer that sits on the producer side of the ALU operation unit.
- Accepts one register-to-register instruction and reads both source operands from the register file through a single read port.
- Drives the ALU operands and operation select, captures the result and status flags, and writes the result back.
- Sits between the instruction source and the datapath (register file + ALU).

---
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue sequencer for one register-to-register
// ALU instruction. Reads both sources through a single register-file read
// port, drives the ALU for one cycle, captures result and flags, and writes
// the result back. Fixed 5-cycle latency per instruction.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int RADDR = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [1:0]       ins_op,
    input  logic             ins_cmp,
    input  logic [RADDR-1:0] ins_rd,
    input  logic [RADDR-1:0] ins_rn,
    input  logic [RADDR-1:0] ins_rm,
    output logic [RADDR-1:0] rf_raddr,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] alu_bin,
    output logic             alu_addsub,
    output logic             alu_sub,
    output logic             alu_and,
    output logic             alu_notb,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             status_z,
    output logic             status_n,
    output logic             status_v,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        EXEC,
        WB
    } state_t;

    // Opcode encodings: 00 ADD, 01 SUB, 10 AND, 11 MVN
    state_t             state, state_nx;
    logic [1:0]         op_q;
    logic               cmp_q;
    logic [RADDR-1:0]   rd_q, rn_q, rm_q;
    logic [WIDTH-1:0]   a_q, b_q, c_q;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore output decode from registered state and fields
    always_comb begin
        state_nx   = state;
        ins_ready  = 1'b0;
        rf_raddr   = '0;
        rf_we      = 1'b0;
        alu_addsub = 1'b0;
        alu_sub    = 1'b0;
        alu_and    = 1'b0;
        alu_notb   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ins_ready = 1'b1;
                if (ins_valid) begin
                    state_nx = RDA;
                end
            end
            RDA: begin
                rf_raddr = rn_q;
                state_nx = RDB;
            end
            RDB: begin
                rf_raddr = rm_q;
                state_nx = EXEC;
            end
            EXEC: begin
                case (op_q)
                    2'b00: alu_addsub = 1'b1;
                    2'b01: begin
                        alu_addsub = 1'b1;
                        alu_sub    = 1'b1;
                    end
                    2'b10: alu_and  = 1'b1;
                    default: alu_notb = 1'b1;
                endcase
                state_nx = WB;
            end
            WB: begin
                done     = 1'b1;
                rf_we    = ~cmp_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Instruction fields, operand/result capture and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            cmp_q    <= 1'b0;
            rd_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_z <= 1'b0;
            status_n <= 1'b0;
            status_v <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ins_valid) begin
                        op_q  <= ins_op;
                        cmp_q <= ins_cmp;
                        rd_q  <= ins_rd;
                        rn_q  <= ins_rn;
                        rm_q  <= ins_rm;
                    end
                end
                RDA: a_q <= rf_rdata;
                RDB: b_q <= rf_rdata;
                EXEC: begin
                    c_q      <= alu_result;
                    status_z <= (alu_result == '0);
                    status_n <= alu_result[WIDTH-1];
                    // Overflow is only meaningful for the adder ops
                    status_v <= (op_q[1] == 1'b0) ? alu_overflow : 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath outputs are held continuously; rf_we alone qualifies the write
    assign rf_waddr = rd_q;
    assign rf_wdata = c_q;
    assign alu_ain  = a_q;
    assign alu_bin  = b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: register file and ALU environment models,
// plus a reference model computing results/flags with signed integer math.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 16;
    localparam int RADDR = 3;

    logic             clk;
    logic             reset;
    logic             ins_valid;
    logic             ins_ready;
    logic [1:0]       ins_op;
    logic             ins_cmp;
    logic [RADDR-1:0] ins_rd, ins_rn, ins_rm;
    logic [RADDR-1:0] rf_raddr;
    logic [WIDTH-1:0] rf_rdata;
    logic             rf_we;
    logic [RADDR-1:0] rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] alu_ain, alu_bin;
    logic             alu_addsub, alu_sub, alu_and, alu_notb;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             status_z, status_n, status_v;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] rf_mem   [8];
    logic [WIDTH-1:0] ref_regs [8];
    logic             pl_en;
    logic [RADDR-1:0] pl_addr;
    logic [WIDTH-1:0] pl_data;
    logic             force_ov;
    logic [WIDTH-1:0] env_res;
    logic             env_ov;

    alu_issue_ctrl #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
        .clk(clk), .reset(reset),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
        .ins_cmp(ins_cmp), .ins_rd(ins_rd), .ins_rn(ins_rn), .ins_rm(ins_rm),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_addsub(alu_addsub),
        .alu_sub(alu_sub), .alu_and(alu_and), .alu_notb(alu_notb),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .status_z(status_z), .status_n(status_n), .status_v(status_v),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: combinational read, write on clock edge
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        else if (pl_en) rf_mem[pl_addr] <= pl_data;
    end

    // ALU environment model
    always_comb begin
        env_res = '0;
        env_ov  = 1'b0;
        if (alu_addsub) begin
            env_res = alu_sub ? (alu_ain - alu_bin) : (alu_ain + alu_bin);
            env_ov  = ((alu_ain[15] == (alu_bin[15] ^ alu_sub)) && (env_res[15] != alu_ain[15]));
        end else if (alu_and) begin
            env_res = alu_ain & alu_bin;
        end else if (alu_notb) begin
            env_res = ~alu_bin;
        end
    end
    assign alu_result   = env_res;
    assign alu_overflow = env_ov | force_ov;

    // Reference: result and signed-overflow from plain integer arithmetic
    function automatic void ref_exec(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] res, output logic v);
        int s;
        s = 0;
        case (op)
            2'd0: s = int'($signed(a)) + int'($signed(b));
            2'd1: s = int'($signed(a)) - int'($signed(b));
            default: s = 0;
        endcase
        if (op == 2'd2) begin
            res = a & b;
            v   = 1'b0;
        end else if (op == 2'd3) begin
            res = ~b;
            v   = 1'b0;
        end else begin
            res = s[15:0];
            v   = (s > 32767) || (s < -32768);
        end
    endfunction

    task automatic preload(input logic [2:0] addr, input logic [15:0] val);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_regs[addr] = val;
    endtask

    // Issue one instruction and check every stage against the reference
    task automatic do_instr(input logic [1:0] op, input logic cmp, input logic [2:0] rd,
                            input logic [2:0] rn, input logic [2:0] rm);
        logic [15:0] a, b, res;
        logic        v;
        int          n;
        a = ref_regs[rn];
        b = ref_regs[rm];
        ref_exec(op, a, b, res, v);
        n = 0;
        @(negedge clk);
        while (!ins_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ins_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout: ins_ready=%b required 1", ins_ready);
            return;
        end
        ins_valid = 1'b1; ins_op = op; ins_cmp = cmp;
        ins_rd = rd; ins_rn = rn; ins_rm = rm;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                checks++;
                if (ins_ready !== 1'b0) begin failures++; $display("FAIL busy_ready k=%0d: got %b required 0", k, ins_ready); end
            end
            if (k == 1) begin
                checks++;
                if (rf_raddr !== rn) begin failures++; $display("FAIL raddr_a: got %0d required %0d", rf_raddr, rn); end
            end
            if (k == 2) begin
                checks++;
                if (rf_raddr !== rm) begin failures++; $display("FAIL raddr_b: got %0d required %0d", rf_raddr, rm); end
            end
            if (k == 3) begin
                checks++;
                if (alu_ain !== a || alu_bin !== b) begin
                    failures++; $display("FAIL operands: got %h/%h required %h/%h", alu_ain, alu_bin, a, b);
                end
                checks++;
                if ({alu_addsub, alu_sub, alu_and, alu_notb} !== {(op <= 2'd1), (op == 2'd1), (op == 2'd2), (op == 2'd3)}) begin
                    failures++;
                    $display("FAIL selects op=%0d: got %b%b%b%b required %b%b%b%b", op, alu_addsub, alu_sub, alu_and, alu_notb,
                             (op <= 2'd1), (op == 2'd1), (op == 2'd2), (op == 2'd3));
                end
            end else begin
                checks++;
                if ({alu_addsub, alu_sub, alu_and, alu_notb} !== 4'b0000) begin
                    failures++; $display("FAIL selects_idle k=%0d: got %b%b%b%b required 0000", k, alu_addsub, alu_sub, alu_and, alu_notb);
                end
            end
            if (k != 4) begin
                checks++;
                if (done !== 1'b0 || rf_we !== 1'b0) begin
                    failures++; $display("FAIL quiet k=%0d: done=%b rf_we=%b required 0/0", k, done, rf_we);
                end
            end else begin
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL done_pulse: got %b required 1", done); end
                checks++;
                if (rf_we !== ~cmp) begin failures++; $display("FAIL rf_we cmp=%b: got %b required %b", cmp, rf_we, ~cmp); end
                if (!cmp) begin
                    checks++;
                    if (rf_waddr !== rd || rf_wdata !== res) begin
                        failures++; $display("FAIL writeback: got R%0d=%h required R%0d=%h", rf_waddr, rf_wdata, rd, res);
                    end
                end
                checks++;
                if ({status_z, status_n, status_v} !== {(res == 16'h0), res[15], v}) begin
                    failures++;
                    $display("FAIL flags op=%0d: got ZNV=%b%b%b required %b%b%b", op, status_z, status_n, status_v, (res == 16'h0), res[15], v);
                end
            end
            if (k == 5) begin
                checks++;
                if (ins_ready !== 1'b1) begin failures++; $display("FAIL ready_after: got %b required 1", ins_ready); end
            end
            // Instruction port activity while busy must be ignored
            if (k <= 3) begin
                ins_valid = 1'($urandom); ins_op = 2'($urandom); ins_cmp = 1'($urandom);
                ins_rd = 3'($urandom); ins_rn = 3'($urandom); ins_rm = 3'($urandom);
            end else begin
                ins_valid = 1'b0;
            end
        end
        if (!cmp) ref_regs[rd] = res;
    endtask

    task automatic test_reset;
        reset = 1'b1; ins_valid = 1'b0; ins_op = '0; ins_cmp = 1'b0;
        ins_rd = '0; ins_rn = '0; ins_rm = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0; force_ov = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ins_ready, done, rf_we, status_z, status_n, status_v} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs: ready/done/we/ZNV=%b%b%b%b%b%b required 100000", ins_ready, done, rf_we, status_z, status_n, status_v);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ins_ready !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0 || rf_raddr !== '0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d: ready=%b done=%b we=%b raddr=%0d required 1 0 0 0", i, ins_ready, done, rf_we, rf_raddr);
            end
        end
        for (int r = 0; r < 8; r++) preload(3'(r), 16'($urandom));
    endtask

    task automatic test_spec_vectors;
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        do_instr(2'd0, 1'b0, 3'd3, 3'd1, 3'd2);
        checks++;
        if (rf_mem[3] !== 16'h8000) begin failures++; $display("FAIL add_r3: got %h required 8000", rf_mem[3]); end
        preload(3'd4, 16'h1234);
        preload(3'd5, 16'h1234);
        do_instr(2'd1, 1'b1, 3'd6, 3'd4, 3'd5);
        preload(3'd1, 16'hF0F0);
        preload(3'd2, 16'h0FF0);
        do_instr(2'd2, 1'b0, 3'd1, 3'd1, 3'd2);
        checks++;
        if (rf_mem[1] !== 16'h00F0) begin failures++; $display("FAIL and_r1: got %h required 00F0", rf_mem[1]); end
        force_ov = 1'b1;
        do_instr(2'd3, 1'b0, 3'd0, 3'd1, 3'd2);
        force_ov = 1'b0;
        checks++;
        if (rf_mem[0] !== 16'hF00F) begin failures++; $display("FAIL mvn_r0: got %h required F00F", rf_mem[0]); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] res1, res2;
        logic        v1, v2;
        int          busy;
        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0005);
        ref_exec(2'd0, ref_regs[1], ref_regs[2], res1, v1);
        ref_regs[5] = res1;
        ref_exec(2'd1, ref_regs[5], ref_regs[1], res2, v2);
        ref_regs[6] = res2;
        @(negedge clk);
        ins_valid = 1'b1; ins_op = 2'd0; ins_cmp = 1'b0; ins_rd = 3'd5; ins_rn = 3'd1; ins_rm = 3'd2;
        @(posedge clk);
        busy = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 4 && ins_ready == 1'b0) busy++;
            if (k == 1) begin ins_op = 2'd1; ins_rd = 3'd6; ins_rn = 3'd5; ins_rm = 3'd1; end
            if (k == 4) begin
                checks++;
                if (done !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== res1) begin
                    failures++; $display("FAIL b2b_first: done=%b we=%b R%0d=%h required 1 1 R5=%h", done, rf_we, rf_waddr, rf_wdata, res1);
                end
            end
            if (k == 5) begin
                checks++;
                if (ins_ready !== 1'b1 || done !== 1'b0) begin
                    failures++; $display("FAIL b2b_gap: ready=%b done=%b required 1 0", ins_ready, done);
                end
            end
            if (k == 6) begin
                checks++;
                if (ins_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept: ready=%b required 0", ins_ready); end
            end
            if (k == 6 || k == 7) ins_valid = 1'($urandom);
            if (k == 8) begin
                ins_valid = 1'b0;
                checks++;
                if (done !== 1'b0) begin failures++; $display("FAIL b2b_early_done: got %b required 0", done); end
            end
            if (k == 9) begin
                checks++;
                if (done !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 3'd6 || rf_wdata !== res2) begin
                    failures++; $display("FAIL b2b_second: done=%b we=%b R%0d=%h required 1 1 R6=%h", done, rf_we, rf_waddr, rf_wdata, res2);
                end
            end
        end
        checks++;
        if (busy != 4) begin failures++; $display("FAIL b2b_busy_cycles: got %0d required 4", busy); end
    endtask

    task automatic test_reset_midop;
        logic [15:0] keep7;
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        do_instr(2'd0, 1'b0, 3'd3, 3'd1, 3'd2);
        keep7 = ref_regs[7];
        @(negedge clk);
        ins_valid = 1'b1; ins_op = 2'd0; ins_cmp = 1'b0; ins_rd = 3'd7; ins_rn = 3'd1; ins_rm = 3'd2;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            ins_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ins_ready, done, rf_we, alu_addsub, status_z, status_n, status_v} !== 7'b1000000) begin
            failures++;
            $display("FAIL midop_reset: ready/done/we/addsub/ZNV=%b%b%b%b%b%b%b required 1000000",
                     ins_ready, done, rf_we, alu_addsub, status_z, status_n, status_v);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0 || done !== 1'b0 || ins_ready !== 1'b1) begin
                failures++; $display("FAIL post_reset cyc=%0d: we=%b done=%b ready=%b required 0 0 1", i, rf_we, done, ins_ready);
            end
        end
        checks++;
        if (rf_mem[7] !== keep7) begin failures++; $display("FAIL aborted_write: R7=%h required %h", rf_mem[7], keep7); end
        do_instr(2'd0, 1'b0, 3'd7, 3'd1, 3'd2);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) preload(3'($urandom), (i % 20 == 0) ? 16'h8000 : 16'($urandom));
            do_instr(2'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 3'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
